rgb_led_arbiter: RTL and testbench

Shares the single on-board RGB LED between several status sources. Each source requests the LED with a 24-bit colour. The block arbitrates with fixed priority and a minimum hold time, then converts the winning colour into three PWM signals. It sits directly in front of the SB_RGBA_DRV current-limited LED driver, whose RGB1PWM/RGB2PWM/RGB0PWM pins it feeds.

---
 rtl/rgb_led_pkg.sv | 33 +++
 rtl/rgb_pwm.sv | 50 +++++
 rtl/rgb_led_arbiter.sv | 148 ++++++++++++++
 tb/tb_rgb_led_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_led_pkg.sv
// Shared types and constants for the RGB LED arbiter and its PWM back end.
// Channel indices follow the SB_RGBA_DRV pin order (RGB0=blue, RGB1=red, RGB2=green).
package rgb_led_pkg;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  localparam int RGB_BLUE  = 0;
  localparam int RGB_RED   = 1;
  localparam int RGB_GREEN = 2;

  localparam logic [7:0] PWM_MAX = 8'hFF;

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_t;

  // One LSB toward the target, holding once equal.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) begin
      return cur + 8'd1;
    end else if (cur > tgt) begin
      return cur - 8'd1;
    end else begin
      return cur;
    end
  endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Free-running 8-bit PWM for three channels; duty is latched once per period so
// colour changes never produce a partial (glitched) period.
module rgb_pwm
  import rgb_led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] cur_color,
  output logic        pwm_red,
  output logic        pwm_green,
  output logic        pwm_blue,
  output logic        frame_start
);

  rgb_t                cur;
  rgb_t                duty;
  logic [PWM_BITS-1:0] cnt;
  logic [2:0]          pwm_q;
  logic                wrap;

  assign cur  = cur_color;
  assign wrap = (cnt == PWM_BITS'(PWM_MAX));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      duty        <= '0;
      pwm_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt + PWM_BITS'(1);
      frame_start <= wrap;
      if (wrap) begin
        duty <= cur;
      end
      pwm_q[RGB_RED]   <= (cnt < duty.red);
      pwm_q[RGB_GREEN] <= (cnt < duty.green);
      pwm_q[RGB_BLUE]  <= (cnt < duty.blue);
    end
  end

  assign pwm_red   = pwm_q[RGB_RED];
  assign pwm_green = pwm_q[RGB_GREEN];
  assign pwm_blue  = pwm_q[RGB_BLUE];

endmodule

// File: rtl/rgb_led_arbiter.sv
// Fixed-priority, minimum-hold arbiter sharing one RGB LED among NREQ sources.
// Optional colour fading is enabled with `define RGB_LED_ARBITER_FADE_EN.
module rgb_led_arbiter
  import rgb_led_pkg::*;
#(
  parameter int NREQ             = 4,
  parameter int PWM_BITS         = 8,
  parameter int HOLD_CYCLES      = 1200000,
  parameter int FADE_STEP_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [24*NREQ-1:0]   color,
  output logic [NREQ-1:0]      grant,
  output logic                 pwm_red,
  output logic                 pwm_green,
  output logic                 pwm_blue,
  output logic                 frame_start
);

  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  arb_state_t        state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [NREQ-1:0]   pick;
  logic              owner_keeps;
  logic              higher_req;
  rgb_t              target;
  rgb_t              cur_rgb;

  // Lowest set bit of req is the highest-priority requester; grant_q - 1 masks
  // every index above the current owner in priority.
  assign pick        = req & (~req + NREQ'(1));
  assign owner_keeps = |(req & grant_q);
  assign higher_req  = |(req & (grant_q - NREQ'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWNED;
          grant_d = pick;
          hold_d  = HOLD_LOAD;
        end
      end
      OWNED: begin
        hold_d = (hold_q != '0) ? hold_q - HOLD_W'(1) : '0;
        if (!owner_keeps) begin
          if (|req) begin
            grant_d = pick;
            hold_d  = HOLD_LOAD;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            hold_d  = '0;
          end
        end else if ((hold_q == '0) && higher_req) begin
          grant_d = pick;
          hold_d  = HOLD_LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Colour is sampled live from the owner every cycle; all-zero grant gives black.
  always_comb begin
    target = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        target = target | color[24*i +: 24];
      end
    end
  end

`ifdef RGB_LED_ARBITER_FADE_EN
  localparam int PS_W = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;

  logic [PS_W-1:0] presc_q;
  logic            fade_tick;

  assign fade_tick = (presc_q == PS_W'(FADE_STEP_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cur_rgb <= '0;
    end else begin
      presc_q <= fade_tick ? '0 : presc_q + PS_W'(1);
      if (fade_tick) begin
        cur_rgb.red   <= step_toward(cur_rgb.red,   target.red);
        cur_rgb.green <= step_toward(cur_rgb.green, target.green);
        cur_rgb.blue  <= step_toward(cur_rgb.blue,  target.blue);
      end
    end
  end
`else
  logic unused_fade_step;
  assign unused_fade_step = ^FADE_STEP_CYCLES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_rgb <= '0;
    end else begin
      cur_rgb <= target;
    end
  end
`endif

  assign grant = grant_q;

  rgb_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk         (clk),
    .rst_n       (rst_n),
    .cur_color   (cur_rgb),
    .pwm_red     (pwm_red),
    .pwm_green   (pwm_green),
    .pwm_blue    (pwm_blue),
    .frame_start (frame_start)
  );

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Self-checking bench for rgb_led_arbiter: cycle-level behavioural model plus
// directed scenarios with hand-computed expectations.
module tb_rgb_led_arbiter;

  localparam int NREQ  = 4;
  localparam int HOLD  = 16;
  localparam int FSTEP = 4;
`ifdef RGB_LED_ARBITER_FADE_EN
  localparam bit FADE_ON = 1'b1;
  localparam int SETTLE  = 1200;
`else
  localparam bit FADE_ON = 1'b0;
  localparam int SETTLE  = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [24*NREQ-1:0] color;
  logic [NREQ-1:0]   grant;
  logic              pwm_red, pwm_green, pwm_blue, frame_start;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rgb_led_arbiter #(
    .NREQ             (NREQ),
    .PWM_BITS         (8),
    .HOLD_CYCLES      (HOLD),
    .FADE_STEP_CYCLES (FSTEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .color       (color),
    .grant       (grant),
    .pwm_red     (pwm_red),
    .pwm_green   (pwm_green),
    .pwm_blue    (pwm_blue),
    .frame_start (frame_start)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_k counts clock edges since reset release; PWM counter value is m_k mod 256.
  // Owner is an index (-1 = idle); age counts edges since the owner was granted.
  int         m_k;
  int         m_owner;
  int         m_age;
  logic [7:0] m_cur  [3];  // 0=red 1=green 2=blue
  logic [7:0] m_duty [3];
  logic       m_pwm  [3];
  logic       m_fs;
  logic [NREQ-1:0] m_grant;

  assign m_grant = (m_owner < 0) ? '0 : NREQ'(1) << m_owner;

  always @(posedge clk or negedge rst_n) begin : model
    int          cnt_old;
    int          lowest;
    int          new_owner;
    int          new_age;
    logic [23:0] tgt;
    logic [7:0]  tch;
    if (!rst_n) begin
      m_k     <= 0;
      m_owner <= -1;
      m_age   <= 0;
      m_fs    <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        m_cur[c]  <= 8'h00;
        m_duty[c] <= 8'h00;
        m_pwm[c]  <= 1'b0;
      end
    end else begin
      cnt_old = m_k % 256;
      tgt     = (m_owner < 0) ? 24'h0 : color[24*m_owner +: 24];
      for (int c = 0; c < 3; c++) begin
        tch = tgt[23-8*c -: 8];
        m_pwm[c] <= (cnt_old < int'(m_duty[c]));
        if (cnt_old == 255) m_duty[c] <= m_cur[c];
        if (!FADE_ON) begin
          m_cur[c] <= tch;
        end else if ((m_k % FSTEP) == FSTEP - 1) begin
          if (m_cur[c] < tch)      m_cur[c] <= m_cur[c] + 8'd1;
          else if (m_cur[c] > tch) m_cur[c] <= m_cur[c] - 8'd1;
        end
      end
      m_fs <= (cnt_old == 255);

      lowest = -1;
      for (int i = NREQ - 1; i >= 0; i--) if (req[i]) lowest = i;
      new_owner = m_owner;
      new_age   = m_age + 1;
      if (m_owner < 0) begin
        if (lowest >= 0) begin
          new_owner = lowest;
          new_age   = 0;
        end
      end else if (!req[m_owner]) begin
        new_owner = lowest;
        new_age   = 0;
      end else if (lowest < m_owner && m_age + 1 > HOLD) begin
        new_owner = lowest;
        new_age   = 0;
      end
      m_owner <= new_owner;
      m_age   <= new_age;
      m_k     <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    check("grant", 32'(grant), 32'(m_grant));
    check("pwm_rgb", 32'({pwm_red, pwm_green, pwm_blue}), 32'({m_pwm[0], m_pwm[1], m_pwm[2]}));
    check("frame_start", 32'(frame_start), 32'(m_fs));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 300);
    check("fs_wait", 32'(frame_start), 32'd1);
  endtask

  task automatic count_period(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < 256; i++) begin
      r += int'(pwm_red);
      g += int'(pwm_green);
      b += int'(pwm_blue);
      @(negedge clk);
    end
  endtask

  task automatic set_color(input int idx, input logic [23:0] c);
    color[24*idx +: 24] = c;
  endtask

  initial begin
    int fs_cnt;
    int r, g, b;
    int n;
    int max_red;

    rst_n = 1'b0;
    req   = '0;
    color = '0;
    step(3);
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_pwm", 32'({pwm_red, pwm_green, pwm_blue}), 32'h0);
    check("reset_fs", 32'(frame_start), 32'h0);
    rst_n = 1'b1;

    // Idle: frame_start pulses at edges 256, 512, 768, 1024.
    fs_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      fs_cnt += int'(frame_start);
    end
    check("idle_fs_count", 32'(fs_cnt), 32'd4);
    check("idle_grant", 32'(grant), 32'h0);

    // Grant latency and minimum hold against a higher-priority request.
    set_color(0, 24'h00_FF_00);
    set_color(2, 24'h80_00_FF);
    set_color(3, 24'h10_20_FF);
    req = 4'b0100;
    step(1);
    check("grant_r2", 32'(grant), 32'b0100);
    step(4);
    req = 4'b0101;
    step(12);
    check("hold_kept", 32'(grant), 32'b0100);
    step(1);
    check("hold_preempt", 32'(grant), 32'b0001);

    // Owner 0 releases; requester 2 takes over on the same edge.
    req = 4'b0100;
    step(1);
    check("release_to_r2", 32'(grant), 32'b0100);
    step(SETTLE);
    wait_fs();
    wait_fs();
    count_period(r, g, b);
    check("duty_red", 32'(r), 32'd128);
    check("duty_green", 32'(g), 32'd0);
    check("duty_blue", 32'(b), 32'd255);

    // Simultaneous requests, then release with no idle gap.
    req = 4'b0000;
    step(2);
    check("back_idle", 32'(grant), 32'h0);
    req = 4'b1001;
    step(1);
    check("simul_r0", 32'(grant), 32'b0001);
    req = 4'b1000;
    step(1);
    check("handover_r3", 32'(grant), 32'b1000);

`ifdef RGB_LED_ARBITER_FADE_EN
    // Fade 0 -> 10 on red with a 4-cycle step: about 40 cycles.
    req = 4'b0000;
    step(255 * FSTEP + 20);
    set_color(1, 24'h0A_00_00);
    req = 4'b0010;
    n = 0;
    while (dut.cur_rgb.red != 8'd10 && n < 100) begin
      step(1);
      n++;
    end
    check("fade_up_reached", 32'(dut.cur_rgb.red), 32'd10);
    check("fade_up_time", 32'(n >= 38 && n <= 41), 32'd1);

    // Redirect mid-fade: back to 0, climb to 5, then retarget to 0.
    set_color(1, 24'h00_00_00);
    step(60);
    set_color(1, 24'h0A_00_00);
    n = 0;
    while (dut.cur_rgb.red != 8'd5 && n < 100) begin
      step(1);
      n++;
    end
    check("fade_mid_reached", 32'(dut.cur_rgb.red), 32'd5);
    set_color(1, 24'h00_00_00);
    max_red = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (int'(dut.cur_rgb.red) > max_red) max_red = int'(dut.cur_rgb.red);
    end
    check("fade_redirect_max", 32'(max_red), 32'd5);
    check("fade_redirect_end", 32'(dut.cur_rgb.red), 32'd0);
    req = 4'b1000;
`endif

    // Asynchronous reset while blue is high.
    step(SETTLE + 600);
    wait_fs();
    step(3);
    @(posedge clk);
    #1;
    check("pre_reset_blue", 32'(pwm_blue), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_pwm", 32'({pwm_red, pwm_green, pwm_blue}), 32'h0);
    check("async_grant", 32'(grant), 32'h0);
    check("async_fs", 32'(frame_start), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(300);
    check("resume_grant", 32'(grant), 32'b1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
